// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and alignment helper for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of a little-endian word and extends it to 32 bits.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = word >> {addr_lo, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    data     = word;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit: byte/half/word loads with extension, sub-word stores
// by read-modify-write against a combinational-read, clocked-write word memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [2:0]               req_funct3_i,
  input  logic [31:0]              req_addr_i,
  input  logic [DATA_WIDTH-1:0]    req_wdata_i,
  output logic                     resp_valid_o,
  output logic [DATA_WIDTH-1:0]    resp_rdata_o,
  output logic                     resp_err_o,
  output logic [ADDRESS_WIDTH-1:0] mem_a_o,
  output logic [DATA_WIDTH-1:0]    mem_wd_o,
  output logic                     mem_wen_o,
  input  logic [DATA_WIDTH-1:0]    mem_rd_i
);

  state_t                   state_q, state_d;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [1:0]               addr_lo_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     err_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [DATA_WIDTH-1:0]    merge_q;
  logic [ADDRESS_WIDTH-1:0] mem_a_q;

  logic                     accept;
  logic                     req_illegal;
  logic                     req_err;
  logic                     sw_write;
  logic [DATA_WIDTH-1:0]    ext_data;
  logic [DATA_WIDTH-1:0]    merged;
  logic                     unused_addr_hi;

  // Address bits above the memory window are deliberately dropped.
  assign unused_addr_hi = ^req_addr_i[31:ADDRESS_WIDTH+2];

  assign accept      = req_valid_i && (state_q == IDLE);
  assign req_illegal = req_we_i ? (req_funct3_i[2] || req_funct3_i[1:0] == 2'b11)
                                : (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11);
  assign req_err     = req_illegal || is_misaligned(req_funct3_i, req_addr_i[1:0]);

  load_extend u_load_extend (
    .word    (mem_rd_i),
    .addr_lo (addr_lo_q),
    .funct3  (f3_q),
    .data    (ext_data)
  );

  always_comb begin
    merged = mem_rd_i;
    if (f3_q[1:0] == 2'b00) begin
      merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_lo_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_err ? RESP : ACCESS;
      ACCESS:  state_d = (we_q && f3_q[1:0] != 2'b10) ? MERGE : RESP;
      MERGE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_lo_q <= 2'b00;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      merge_q   <= '0;
      mem_a_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q      <= req_we_i;
        f3_q      <= req_funct3_i;
        addr_lo_q <= req_addr_i[1:0];
        wdata_q   <= req_wdata_i;
        err_q     <= req_err;
        rdata_q   <= '0;
        if (!req_err) mem_a_q <= req_addr_i[ADDRESS_WIDTH+1:2];
      end
      if (state_q == ACCESS && !we_q) rdata_q <= ext_data;
      if (state_q == ACCESS && we_q)  merge_q <= merged;
    end
  end

  // Reset gates the strobes combinationally so an in-flight MERGE write never commits.
  assign sw_write     = (state_q == ACCESS) && we_q && (f3_q[1:0] == 2'b10);
  assign req_ready_o  = (state_q == IDLE) && !rst_i;
  assign resp_valid_o = (state_q == RESP) && !rst_i;
  assign resp_err_o   = resp_valid_o && err_q;
  assign resp_rdata_o = resp_valid_o ? rdata_q : '0;
  assign mem_a_o      = mem_a_q;
  assign mem_wen_o    = !rst_i && (sw_write || state_q == MERGE);
  assign mem_wd_o     = sw_write ? wdata_q : ((state_q == MERGE) ? merge_q : '0);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed scenarios plus randomized traffic vs. a byte-level model.
module tb_load_store_unit;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [2:0]    req_funct3_i;
  logic [31:0]   req_addr_i;
  logic [31:0]   req_wdata_i;
  logic          resp_valid_o;
  logic [31:0]   resp_rdata_o;
  logic          resp_err_o;
  logic [AW-1:0] mem_a_o;
  logic [31:0]   mem_wd_o;
  logic          mem_wen_o;
  logic [31:0]   mem_rd_i;

  always #5 clk = ~clk;

  load_store_unit #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .mem_a_o      (mem_a_o),
    .mem_wd_o     (mem_wd_o),
    .mem_wen_o    (mem_wen_o),
    .mem_rd_i     (mem_rd_i)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] lat;
    logic [31:0] acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        force_ff;
  logic        init_mem;
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_val;
  int          cyc = 0;
  int          wen_cnt = 0;
  int          total = 0;
  int          passed = 0;

  function automatic logic [31:0] init_val(input int i);
    return 32'h9E3779B9 * 32'(i) + 32'h01234567;
  endfunction

  // Behavioural memory: combinational read, write committed at the rising edge.
  assign mem_rd_i = force_ff ? 32'hFFFFFFFF : mem[mem_a_o[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end else if (mem_wen_o) begin
      mem[mem_a_o[7:0]] <= mem_wd_o;
    end
    if (mem_wen_o) wen_cnt <= wen_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: byte-granular view of the access rules.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t r;
    int nbytes = 1 << f3[1:0];
    int off = int'(addr % 4);
    int idx = int'(addr[9:2]);
    logic [31:0] v;
    logic err = (f3[1:0] == 2'b11) || (we && f3[2]) || (!we && f3 == 3'b110) ||
                ((off % nbytes) != 0);
    r.rdata = 32'd0;
    r.err = err;
    r.acc = 32'd0;
    if (err) begin
      r.lat = 32'd1;
    end else if (!we) begin
      v = ref_mem[idx] >> (8 * off);
      if (nbytes == 1) begin
        v = v & 32'h000000FF;
        if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
      end else if (nbytes == 2) begin
        v = v & 32'h0000FFFF;
        if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
      end
      r.rdata = v;
      r.lat = 32'd2;
    end else begin
      for (int i = 0; i < nbytes; i++) ref_mem[idx][8*(off+i) +: 8] = wd[8*i +: 8];
      r.lat = (nbytes == 4) ? 32'd2 : 32'd3;
    end
    return r;
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit hold, input bit track, output int acc);
    exp_t e;
    int n = 0;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_we_i = we;
    req_funct3_i = f3;
    req_addr_i = addr;
    req_wdata_i = wd;
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid_i = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (track) begin
      e = model(we, f3, addr, wd);
      e.acc = 32'(acc);
      sb.push_back(e);
    end
    if (!hold) req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !req_ready_o) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !req_ready_o) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1;
    poke_idx = 8'(idx);
    poke_val = val;
    @(posedge clk);
    #1;
    poke_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  always @(negedge clk) begin
    if (resp_valid_o) begin
      if (sb.size() == 0) begin
        chk("spurious_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_rdata", resp_rdata_o, mon_e.rdata);
        chk("resp_err", 32'(resp_err_o), 32'(mon_e.err));
        chk("resp_latency", 32'(cyc) - mon_e.acc + 32'd1, mon_e.lat);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int a1, a2, acc, w0, bad;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;

    rst_i = 1'b1;
    force_ff = 1'b1;
    init_mem = 1'b1;
    poke_en = 1'b0;
    poke_idx = 8'd0;
    poke_val = 32'd0;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_funct3_i = 3'b000;
    req_addr_i = 32'd0;
    req_wdata_i = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    @(negedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_resp_err", 32'(resp_err_o), 32'd0);
    chk("rst_resp_rdata", resp_rdata_o, 32'd0);
    chk("rst_mem_wen", 32'(mem_wen_o), 32'd0);
    chk("rst_mem_a", 32'(mem_a_o), 32'd0);
    chk("rst_mem_wd", mem_wd_o, 32'd0);
    rst_i = 1'b0;
    force_ff = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready_o), 32'd1);

    // Word load and address mapping
    poke(4, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'd0, 1'b0, 1'b1, acc);
    chk("lw_mem_a", 32'(mem_a_o), 32'd4);
    drain();

    // Sub-word loads with sign/zero extension
    poke(4, 32'h80FF7F01);
    issue(1'b0, 3'b000, 32'h13, 32'd0, 1'b0, 1'b1, acc);
    issue(1'b0, 3'b100, 32'h13, 32'd0, 1'b0, 1'b1, acc);
    issue(1'b0, 3'b001, 32'h12, 32'd0, 1'b0, 1'b1, acc);
    issue(1'b0, 3'b101, 32'h12, 32'd0, 1'b0, 1'b1, acc);
    drain();

    // Byte store read-modify-write
    poke(8, 32'h11223344);
    drain();
    w0 = wen_cnt;
    issue(1'b1, 3'b000, 32'h21, 32'h000000AB, 1'b0, 1'b1, acc);
    drain();
    chk("sb_wen_count", 32'(wen_cnt - w0), 32'd1);
    chk("sb_word", mem[8], 32'h1122AB44);

    // Error requests never touch memory
    w0 = wen_cnt;
    issue(1'b1, 3'b001, 32'h03, 32'h1234, 1'b0, 1'b1, acc);
    issue(1'b0, 3'b010, 32'h02, 32'd0, 1'b0, 1'b1, acc);
    issue(1'b0, 3'b011, 32'h40, 32'd0, 1'b0, 1'b1, acc);
    issue(1'b1, 3'b100, 32'h44, 32'h55, 1'b0, 1'b1, acc);
    drain();
    chk("err_no_wen", 32'(wen_cnt - w0), 32'd0);

    // Back-to-back stores with valid held high
    issue(1'b1, 3'b010, 32'h80, $urandom, 1'b1, 1'b1, a1);
    issue(1'b1, 3'b010, 32'h84, $urandom, 1'b0, 1'b1, a2);
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd3);
    drain();

    // Reset during MERGE of a halfword store
    w0 = wen_cnt;
    issue(1'b1, 3'b001, 32'h30, 32'h00005A5A, 1'b0, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("midop_rst_ready", 32'(req_ready_o), 32'd0);
    chk("midop_rst_wen", 32'(mem_wen_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("midop_ready_after", 32'(req_ready_o), 32'd1);
    chk("midop_no_write", 32'(wen_cnt - w0), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      if (we && f3 == 3'b011) f3 = 3'b010;
      addr = $urandom;
      if ($urandom % 4 != 0) begin
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      issue(we, f3, addr, $urandom, ($urandom % 3) == 0, 1'b1, acc);
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    drain();

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_contents", 32'(bad), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
